// File: rtl/bus_timer_responder_if.sv
// CPU data-bus bundle shared by the memory block and bus_timer_responder.
// The master side drives address/write data/strobe; a responder returns
// registered read data plus a hit flag so the top level can mux read paths.
interface bus_timer_responder_if;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       write;
  logic [7:0] data_out;
  logic       hit;

  modport master (
    output address,
    output data_in,
    output write,
    input  data_out,
    input  hit
  );

  modport slave (
    input  address,
    input  data_in,
    input  write,
    output data_out,
    output hit
  );
endinterface

// File: rtl/bus_timer_responder.sv
// Memory-mapped timer responder: 8-byte register window at BASE_ADDR with
// prescaled counter, compare match flag, interrupt and 1-cycle registered
// read data. Optional input capture is built when TIMER_CAPTURE_EN is defined;
// without it capture_in is ignored and CAPTURE / STATUS bit2 read 0.
module bus_timer_responder #(
  parameter logic [7:0] BASE_ADDR = 8'hD8,
  parameter int         CNT_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  bus_timer_responder_if.slave  bus,
  output logic                  irq,
  input  logic                  capture_in
);

  logic             sel;
  logic [2:0]       offset;
  logic             wr;
  logic             tick;
  logic             match_set;

  logic             enable_q, enable_d;
  logic             auto_reload_q, auto_reload_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] prescale_q, prescale_d;
  logic [CNT_W-1:0] compare_q, compare_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             match_flag_q, match_flag_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             hit_q, hit_d;
  logic             irq_q, irq_d;

  logic [7:0]       capture_rd;
  logic             capture_flag_rd;

  assign sel    = (bus.address[7:3] == BASE_ADDR[7:3]);
  assign offset = bus.address[2:0];
  assign wr     = bus.write && sel;

`ifdef TIMER_CAPTURE_EN
  logic             cap_sync1_q, cap_sync2_q, cap_prev_q;
  logic             cap_rise;
  logic [CNT_W-1:0] capture_q, capture_d;
  logic             capture_flag_q, capture_flag_d;

  assign cap_rise        = cap_sync2_q && !cap_prev_q;
  assign capture_rd      = capture_q;
  assign capture_flag_rd = capture_flag_q;

  // Synchronize the asynchronous capture strobe and hold the captured value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_sync1_q    <= 1'b0;
      cap_sync2_q    <= 1'b0;
      cap_prev_q     <= 1'b0;
      capture_q      <= '0;
      capture_flag_q <= 1'b0;
    end else begin
      cap_sync1_q    <= capture_in;
      cap_sync2_q    <= cap_sync1_q;
      cap_prev_q     <= cap_sync2_q;
      capture_q      <= capture_d;
      capture_flag_q <= capture_flag_d;
    end
  end
`else
  logic unused_capture_in;
  assign unused_capture_in = capture_in;
  assign capture_rd        = 8'h00;
  assign capture_flag_rd   = 1'b0;
`endif

  // Next-state: prescaler, counter/compare, bus writes (win over ticks) and read mux.
  always_comb begin
    enable_d      = enable_q;
    auto_reload_d = auto_reload_q;
    irq_en_d      = irq_en_q;
    prescale_d    = prescale_q;
    compare_d     = compare_q;
    count_d       = count_q;
    match_flag_d  = match_flag_q;
    pcnt_d        = '0;
    match_set     = 1'b0;
    data_out_d    = 8'h00;
    hit_d         = sel;
    irq_d         = match_flag_q && irq_en_q;
`ifdef TIMER_CAPTURE_EN
    capture_d      = capture_q;
    capture_flag_d = capture_flag_q;
    if (cap_rise) capture_d = count_q;
`endif

    tick = enable_q && (pcnt_q == prescale_q);
    if (enable_q && !tick) pcnt_d = pcnt_q + 1'b1;

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        if (auto_reload_q) count_d = '0;
        else               enable_d = 1'b0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (wr) begin
      case (offset)
        3'd0: begin
          enable_d      = bus.data_in[0];
          auto_reload_d = bus.data_in[1];
          irq_en_d      = bus.data_in[3];
          if (bus.data_in[0] && !enable_q) pcnt_d = '0;
        end
        3'd1: begin
          prescale_d = bus.data_in;
          pcnt_d     = '0;
        end
        3'd2: compare_d = bus.data_in;
        3'd3: count_d   = bus.data_in;
        3'd4: begin
          if (bus.data_in[0]) match_flag_d = 1'b0;
`ifdef TIMER_CAPTURE_EN
          if (bus.data_in[2]) capture_flag_d = 1'b0;
`endif
        end
        default: ;
      endcase
    end

    if (match_set) match_flag_d = 1'b1;
`ifdef TIMER_CAPTURE_EN
    if (cap_rise) capture_flag_d = 1'b1;
`endif

    if (sel) begin
      case (offset)
        3'd0: data_out_d = {4'b0000, irq_en_q, 1'b0, auto_reload_q, enable_q};
        3'd1: data_out_d = prescale_q;
        3'd2: data_out_d = compare_q;
        3'd3: data_out_d = count_q;
        3'd4: data_out_d = {5'b00000, capture_flag_rd, enable_q, match_flag_q};
        3'd5: data_out_d = capture_rd;
        default: data_out_d = 8'h00;
      endcase
    end
  end

  // State register; reset clears every register, the prescaler and the outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_q      <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      prescale_q    <= '0;
      compare_q     <= '0;
      count_q       <= '0;
      pcnt_q        <= '0;
      match_flag_q  <= 1'b0;
      data_out_q    <= 8'h00;
      hit_q         <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      enable_q      <= enable_d;
      auto_reload_q <= auto_reload_d;
      irq_en_q      <= irq_en_d;
      prescale_q    <= prescale_d;
      compare_q     <= compare_d;
      count_q       <= count_d;
      pcnt_q        <= pcnt_d;
      match_flag_q  <= match_flag_d;
      data_out_q    <= data_out_d;
      hit_q         <= hit_d;
      irq_q         <= irq_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.hit      = hit_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Self-checking bench for bus_timer_responder (default build, capture disabled).
// A register-file level reference model predicts every read, hit and irq.
module tb_bus_timer_responder;
  localparam logic [7:0] BASE = 8'hD8;

  logic clock = 1'b0;
  logic reset;
  logic irq;
  logic capture_in;

  bus_timer_responder_if bus ();

  bus_timer_responder #(.BASE_ADDR(BASE), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .irq        (irq),
    .capture_in (capture_in)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: the register file as the CPU sees it, plus the number
  // of clocks elapsed since the last tick or prescaler restart.
  logic [7:0] m_reg [0:7];
  bit         m_en, m_ar, m_ie, m_flag;
  int         m_since;

  logic [7:0] rd_val;
  int         first_seen;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_en = 0; m_ar = 0; m_ie = 0; m_flag = 0; m_since = 0;
  endtask

  function automatic logic [7:0] modelRead(input logic [7:0] a);
    if (a[7:3] != BASE[7:3]) return 8'h00;
    case (a[2:0])
      3'd0: return {4'b0000, m_ie, 1'b0, m_ar, m_en};
      3'd1: return m_reg[1];
      3'd2: return m_reg[2];
      3'd3: return m_reg[3];
      3'd4: return {6'b0, m_en, m_flag};
      default: return 8'h00;
    endcase
  endfunction

  // One clock of timer behaviour: a tick every PRESCALE+1 enabled clocks;
  // bus writes override the timer, a new match overrides a flag clear.
  task automatic modelAdvance(input logic [7:0] a, input logic [7:0] d, input bit w);
    bit tick, match, in_win;
    int since_n;
    in_win  = (a[7:3] == BASE[7:3]);
    tick    = m_en && (m_since == int'(m_reg[1]));
    match   = tick && (m_reg[3] == m_reg[2]);
    since_n = (m_en && !tick) ? m_since + 1 : 0;
    if (tick) begin
      if (!match)    m_reg[3] = 8'((int'(m_reg[3]) + 1) % 256);
      else if (m_ar) m_reg[3] = 8'h00;
      else           m_en = 0;
    end
    if (w && in_win) begin
      case (a[2:0])
        3'd0: begin
          if (d[0] && !m_en) since_n = 0;
          m_en = d[0]; m_ar = d[1]; m_ie = d[3];
        end
        3'd1: begin m_reg[1] = d; since_n = 0; end
        3'd2: m_reg[2] = d;
        3'd3: m_reg[3] = d;
        3'd4: if (d[0]) m_flag = 0;
        default: ;
      endcase
    end
    if (match) m_flag = 1;
    m_since = since_n;
  endtask

  // Drive one bus cycle, then check the registered read, hit and irq.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] d, input bit w);
    logic [7:0] exp_rd;
    logic       exp_hit, exp_irq;
    bus.address = a;
    bus.data_in = d;
    bus.write   = w;
    exp_rd  = modelRead(a);
    exp_hit = (a[7:3] == BASE[7:3]);
    exp_irq = m_flag && m_ie;
    @(posedge clock);
    modelAdvance(a, d, w);
    #1;
    rd_val = bus.data_out;
    checkOutput($sformatf("%s.data", tag), bus.data_out, exp_rd);
    checkOutput($sformatf("%s.hit", tag), {7'b0, bus.hit}, {7'b0, exp_hit});
    checkOutput($sformatf("%s.irq", tag), {7'b0, irq}, {7'b0, exp_irq});
  endtask

  task automatic wr(input string tag, input logic [2:0] off, input logic [7:0] d);
    applyStimulus(tag, BASE + 8'(off), d, 1'b1);
  endtask

  task automatic rd(input string tag, input logic [2:0] off);
    applyStimulus(tag, BASE + 8'(off), 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1; capture_in = 1'b0;
    bus.address = 8'h00; bus.data_in = 8'h00; bus.write = 1'b0;
    modelReset();
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset.data", bus.data_out, 8'h00);
    checkOutput("reset.hit", {7'b0, bus.hit}, 8'h00);
    checkOutput("reset.irq", {7'b0, irq}, 8'h00);
    reset = 1'b0;

    // Reset values of the whole window, then a miss
    for (int i = 0; i < 8; i++) rd("rst_win", 3'(i));
    applyStimulus("miss", 8'h10, 8'h00, 1'b0);

    // Periodic auto-reload: match should be visible 25 reads after enable
    wr("per_pre", 3'd1, 8'h03);
    wr("per_cmp", 3'd2, 8'h05);
    wr("per_ctrl", 3'd0, 8'h0B);
    first_seen = -1;
    for (int i = 1; i <= 40; i++) begin
      rd("per_stat", 3'd4);
      if (first_seen < 0 && rd_val[0]) first_seen = i;
    end
    checkOutput("per_latency", 8'(first_seen), 8'd25);
    for (int i = 0; i < 10; i++) rd("per_cnt", 3'd3);
    wr("per_clr", 3'd4, 8'h01);
    rd("per_stat2", 3'd4);
    wr("per_off", 3'd0, 8'h00);
    wr("per_clr2", 3'd4, 8'h01);

    // One-shot: counts 0,1,2 then stops with the flag set
    wr("os_pre", 3'd1, 8'h00);
    wr("os_cmp", 3'd2, 8'h02);
    wr("os_cnt", 3'd3, 8'h00);
    wr("os_ctrl", 3'd0, 8'h01);
    for (int i = 0; i < 6; i++) rd("os_cnt_rd", 3'd3);
    checkOutput("os_hold", rd_val, 8'h02);
    rd("os_stat", 3'd4);
    checkOutput("os_status", rd_val, 8'h01);

    // Flag clear colliding with a new match: the match wins
    wr("cm_clr", 3'd4, 8'h01);
    wr("cm_cnt", 3'd3, 8'h03);
    wr("cm_cmp", 3'd2, 8'h03);
    wr("cm_ctrl", 3'd0, 8'h03);
    wr("cm_clr_hit", 3'd4, 8'h01);
    rd("cm_stat", 3'd4);
    checkOutput("cm_flag_kept", rd_val, 8'h03);
    wr("cm_off", 3'd0, 8'h00);
    wr("cm_clr2", 3'd4, 8'h01);

    // Wrap 255 -> 0 without a flag, then a bus write beating a tick
    wr("wr_cnt", 3'd3, 8'hFF);
    wr("wr_cmp", 3'd2, 8'h10);
    wr("wr_ctrl", 3'd0, 8'h01);
    rd("wr_rd0", 3'd3);
    rd("wr_rd1", 3'd3);
    checkOutput("wrap_zero", rd_val, 8'h00);
    rd("wr_stat", 3'd4);
    checkOutput("wrap_noflag", rd_val, 8'h02);
    wr("wr_force", 3'd3, 8'h40);
    rd("wr_after", 3'd3);
    checkOutput("write_beats_tick", rd_val, 8'h40);
    wr("wr_off", 3'd0, 8'h00);

    // Randomized traffic, mostly in-window, small prescale/compare values
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a, d;
      bit w;
      a = ($urandom_range(0, 15) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 7));
      d = 8'($urandom);
      w = ($urandom_range(0, 3) == 0);
      if (a[2:0] == 3'd1 || a[2:0] == 3'd2) d = d % 8'd6;
      if (a[2:0] == 3'd3 && d[7:6] != 2'b11) d = d % 8'd8;
      capture_in = 1'($urandom);
      applyStimulus("rand", a, d, w);
    end
    capture_in = 1'b0;
    rd("rand_cap", 3'd5);
    checkOutput("capture_absent", rd_val, 8'h00);

    // Asynchronous reset while counting
    wr("ar_pre", 3'd1, 8'h01);
    wr("ar_cmp", 3'd2, 8'h03);
    wr("ar_ctrl", 3'd0, 8'h0B);
    for (int i = 0; i < 12; i++) rd("ar_run", 3'd3);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst.data", bus.data_out, 8'h00);
    checkOutput("async_rst.hit", {7'b0, bus.hit}, 8'h00);
    checkOutput("async_rst.irq", {7'b0, irq}, 8'h00);
    @(posedge clock);
    #1 reset = 1'b0;
    modelReset();
    for (int i = 0; i < 8; i++) rd("post_rst", 3'(i));
    for (int i = 0; i < 4; i++) rd("post_rst_cnt", 3'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
